serial_sub_arbiter: RTL
=======================

# serial_sub_arbiter

Bit-serial subtraction engine that shares one 1-bit subtract cell between two requesters. Each granted request computes `diff = (a - b) mod 2^WIDTH` and `borrow = (a < b)` LSB-first, one bit per clock, with a registered borrow chain. A round-robin arbiter picks the requester, and a valid/grant handshake moves operands and results. It sits between two client datapaths and the shared subtractor resource, replacing two parallel WIDTH-bit subtractors.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be at least 2.

- `clk`  in  1  the only clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0`  in  1  requester 0 asks for a subtraction; held until `gnt0`
- `a0`, `b0`  in  WIDTH each  requester 0 minuend and subtrahend; stable while `req0` is high
- `gnt0`  out  1  one-cycle pulse: requester 0 operands were captured on this edge
- `req1`, `a1`, `b1`, `gnt1`: same as above, for requester 1
- `busy`  out  1  engine is shifting bits (SHIFT state)
- `done`  out  1  one-cycle pulse: `diff`, `borrow`, `ovf` and `owner` are valid
- `owner`  out  1  index of the requester whose result is presented
- `diff`  out  WIDTH  difference, held until the next `done`
- `borrow`  out  1  final borrow out (1 means unsigned `a < b`), held like `diff`
- `ovf`  out  1  signed overflow flag (see Configuration)

## Operation
- States:
  - IDLE: arbitrates.
  - SHIFT: `busy` is 1; bit counter `cnt` runs from 0 to WIDTH-1.
  - DONE: `done` is 1 for one cycle. DONE also arbitrates, so operations can run back to back.
- Arbitration (in IDLE or DONE, at a rising edge):
  - Only one request high: grant it.
  - Both high: grant the requester not served last.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- Grant edge:
  - The matching `gnt` is 1 for that cycle.
  - Operands are latched into shift registers, borrow flop is cleared, `cnt` = 0, `owner_next` is latched, and the state moves to SHIFT.
- SHIFT edge for bit i, with `a` = a[i], `b` = b[i], `bin` = borrow flop:
  - `d = a ^ b ^ bin`
  - `bout = (~a & b) | (~(a ^ b) & bin)`
  - `d` is shifted into the result register MSB-side, right-shifting; `bin` takes `bout`.
- On the edge with `cnt == WIDTH-1`: `diff`, `borrow`, `ovf` and `owner` load together, and the state moves to DONE.
- A `req` deasserted before its `gnt` is a withdrawal and has no effect.
- A request still high after its `gnt` edge is a new request.
- Requests are ignored during SHIFT. No queueing and no preemption.

## Timing
- E0 is the grant edge.
  - Bits are processed on edges E1 through E_WIDTH.
  - `done` is high from E_WIDTH to E_WIDTH+1.
  - The earliest next grant is at E_WIDTH+1 (from DONE).
- Latency from grant to result is WIDTH edges. Throughput is one operation per WIDTH+1 cycles.
- `gnt0`, `gnt1`, `busy`, `done` and all result outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values, applied immediately on `rst_n` low:
  - `gnt0`, `gnt1`, `busy`, `done`, `owner`, `diff`, `borrow`, `ovf` are 0.
  - State is IDLE and the pointer is 1.
- Reset during SHIFT aborts the operation: no `done` pulse and no partial result. The first edge after reset release may grant.
- Arithmetic matches a WIDTH+1-bit `{borrow, diff} = a - b`.
  - a == b gives diff 0, borrow 0.
  - 0 - 1 gives all ones, borrow 1.

## Configuration
- `SERIAL_SUB_OVF_EN`
  - Defined: `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated from latched operand sign bits and loaded with `diff`.
  - Undefined: `ovf` is tied to 0 and the sign-bit capture logic is omitted.
  - The port list is identical either way.

## Test plan
All scenarios use WIDTH=8.
- `req0`, a0=8'h5A, b0=8'h23: `gnt0` at E0, then at E8 `done`=1, diff=8'h37, borrow=0, owner=0.
- `req1`, a1=8'h10, b1=8'h20: diff=8'hF0, borrow=1, owner=1. Then a=b=8'hFF gives diff=8'h00, borrow=0. Then a=8'h00, b=8'h01 gives diff=8'hFF, borrow=1.
- `req0` and `req1` high after reset, both held:
  - `gnt0` at E0 and `done` at E8.
  - `gnt1` at E9, during DONE; `done` at E17 with owner=1.
  - Next tie goes to requester 0.
- `req0` held through its grant: regranted at E9. `req1` pulsed during SHIFT and dropped before E9: never granted.
- `rst_n` low at E4 of an operation: `busy`, `diff` and `borrow` are 0 immediately, and no `done` occurs. After release with both requests high, `gnt0` wins.
- a=8'h80, b=8'h01: diff=8'h7F, borrow=0, `ovf`=1 with `SERIAL_SUB_OVF_EN`, `ovf`=0 without. a=8'h7F, b=8'h01 gives `ovf`=0 in both builds.

Source files
------------

// File: rtl/serial_sub_arbiter.sv
// Two-requester round-robin front end for one shared bit-serial subtractor. A result appears
// WIDTH edges after the grant; define SERIAL_SUB_OVF_EN to enable the signed overflow flag.
module serial_sub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_last;
    logic             r_gnt0, r_gnt1, r_busy, r_done;
    logic             r_owner_nxt, r_owner;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
    logic             r_bin, r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_arb, w_sel0, w_sel1, w_grant, w_last_bit;
    logic             w_d, w_bout;
    logic [WIDTH-1:0] w_op_a, w_op_b;

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = (r_state != S_SHIFT);
        // Tie goes to the requester that was not served last.
        w_sel0      = w_arb & req0 & (~req1 | r_last);
        w_sel1      = w_arb & req1 & (~req0 | ~r_last);
        w_grant     = w_sel0 | w_sel1;
        w_op_a      = w_sel1 ? a1 : a0;
        w_op_b      = w_sel1 ? b1 : b0;
        w_last_bit  = (r_cnt == CW'(WIDTH - 1));
        w_d         = r_a[0] ^ r_b[0] ^ r_bin;
        w_bout      = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = w_grant ? S_SHIFT : S_IDLE;
            S_SHIFT:        w_state_nxt = w_last_bit ? S_DONE : S_SHIFT;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_owner_nxt <= 1'b0;
            r_owner     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_diff      <= '0;
            r_bin       <= 1'b0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_gnt0 <= w_sel0;
            r_gnt1 <= w_sel1;
            if (w_grant) begin
                r_a         <= w_op_a;
                r_b         <= w_op_b;
                r_bin       <= 1'b0;
                r_cnt       <= '0;
                r_owner_nxt <= w_sel1;
                r_last      <= w_sel1;
            end else if (r_state == S_SHIFT) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_bin <= w_bout;
                r_cnt <= r_cnt + CW'(1);
                if (w_last_bit) begin
                    r_diff   <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_owner  <= r_owner_nxt;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_sa, r_sb, r_ovf;

    // The shift registers lose the sign bits, so keep copies for the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_grant) begin
            r_sa <= w_op_a[WIDTH-1];
            r_sb <= w_op_b[WIDTH-1];
        end else if (r_state == S_SHIFT && w_last_bit) begin
            r_ovf <= (r_sa != r_sb) && (w_d != r_sa);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign busy   = r_busy;
    assign done   = r_done;
    assign owner  = r_owner;
    assign diff   = r_diff;
    assign borrow = r_borrow;
endmodule
